pwr_boot_seq: RTL and testbench

Power-up and boot sequencer for the TMS320VC5509A, implemented in the board CPLD. It sits upstream of the DSP's boot path. It enables the DSP core regulator and waits for power-good. It then holds the DSP in reset with the boot-mode pins driven, releases reset, and watches the DSP's SPI chip-select on the boot-EEPROM bus to confirm the boot image was read. A boot that never touches the EEPROM is retried with a full power cycle, up to a limit, before the block latches a fault.

---
 rtl/pwr_boot_seq.sv | 161 ++++++++++++++++
 tb/tb_pwr_boot_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_boot_seq.sv
// Power-up and boot sequencer for the TMS320VC5509A: regulator enable, reset hold,
// SPI-EEPROM boot confirmation through chip-select activity, retry with power cycle, fault latch.
module pwr_boot_seq #(
    parameter logic [3:0] BOOTCFG      = 4'b1001,
    parameter int         CNT_W        = 24,
    parameter int         PG_TIMEOUT   = 1_000_000,
    parameter int         RST_HOLD     = 100_000,
    parameter int         BOOT_TIMEOUT = 4_000_000,
    parameter int         QUIET        = 50_000,
    parameter int         OFF_CYCLES   = 500_000,
    parameter int         MAX_RETRY    = 3
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       pwr_good,
    input  logic       cs,
    output logic       pwr_en,
    output logic       dsp_rst_n,
    output logic [3:0] bootcfg,
    output logic       boot_done,
    output logic       fault,
    output logic [2:0] state
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   PG_LAST    = CNT_W'(PG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]   BOOT_LAST  = CNT_W'(BOOT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   QUIET_LAST = CNT_W'(QUIET - 1);
    localparam logic [CNT_W-1:0]   OFF_LAST   = CNT_W'(OFF_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EN_PWR   = 3'd1,
        HOLD_RST = 3'd2,
        BOOT     = 3'd3,
        DONE     = 3'd4,
        OFF      = 3'd5,
        FAULT    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               cs_seen_q, cs_seen_d;
    logic               pg_meta_q, pg_s_q;
    logic               cs_meta_q, cs_s_q, cs_prev_q;
    logic               pwr_en_q, pwr_en_d;
    logic               dsp_rst_n_q, dsp_rst_n_d;
    logic [3:0]         bootcfg_q, bootcfg_d;
    logic               boot_done_q, boot_done_d;
    logic               fault_q, fault_d;
    logic               cs_fall, seen_now;

    // Synchronisers reset to the inactive level so a reset never looks like activity.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pg_meta_q <= 1'b0;
            pg_s_q    <= 1'b0;
            cs_meta_q <= 1'b1;
            cs_s_q    <= 1'b1;
            cs_prev_q <= 1'b1;
        end else begin
            pg_meta_q <= pwr_good;
            pg_s_q    <= pg_meta_q;
            cs_meta_q <= cs;
            cs_s_q    <= cs_meta_q;
            cs_prev_q <= cs_s_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            cs_seen_q   <= 1'b0;
            pwr_en_q    <= 1'b0;
            dsp_rst_n_q <= 1'b0;
            bootcfg_q   <= 4'b0000;
            boot_done_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            cs_seen_q   <= cs_seen_d;
            pwr_en_q    <= pwr_en_d;
            dsp_rst_n_q <= dsp_rst_n_d;
            bootcfg_q   <= bootcfg_d;
            boot_done_q <= boot_done_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        cs_fall     = cs_prev_q & ~cs_s_q;
        // A falling edge on the terminal-count cycle still counts as boot activity.
        seen_now    = cs_seen_q | cs_fall;

        case (state_q)
            IDLE: state_d = EN_PWR;
            EN_PWR: begin
                cnt_d = cnt_q + 1'b1;
                if (pg_s_q)                 state_d = HOLD_RST;
                else if (cnt_q == PG_LAST)  state_d = FAULT;
            end
            HOLD_RST: begin
                cnt_d = cnt_q + 1'b1;
                if (!pg_s_q)                state_d = OFF;
                else if (cnt_q == HOLD_LAST) state_d = BOOT;
            end
            BOOT: begin
                cnt_d = cnt_q + 1'b1;
                if (!pg_s_q)                              state_d = OFF;
                else if (!seen_now && cnt_q == BOOT_LAST) state_d = OFF;
                else if (seen_now && !cs_s_q)             cnt_d   = '0;
                else if (seen_now && cnt_q == QUIET_LAST) state_d = DONE;
            end
            DONE: if (!pg_s_q) state_d = FAULT;
            OFF: begin
                cnt_d = cnt_q + 1'b1;
                if (retry_q == RETRY_MAX) begin
                    state_d = FAULT;
                end else if (cnt_q == OFF_LAST) begin
                    state_d = EN_PWR;
                    retry_d = retry_q + 1'b1;
                end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        if (state_d == BOOT && state_q != BOOT) cs_seen_d = 1'b0;
        else if (cs_fall)                       cs_seen_d = 1'b1;
        else                                    cs_seen_d = cs_seen_q;

        pwr_en_d    = (state_d == EN_PWR) || (state_d == HOLD_RST) ||
                      (state_d == BOOT)   || (state_d == DONE);
        dsp_rst_n_d = (state_d == BOOT) || (state_d == DONE);
        // Unpowered DSP pins are driven low so they are not back-powered.
        bootcfg_d   = pwr_en_d ? BOOTCFG : 4'b0000;
        boot_done_d = (state_d == DONE);
        fault_d     = (state_d == FAULT);
    end

    assign pwr_en    = pwr_en_q;
    assign dsp_rst_n = dsp_rst_n_q;
    assign bootcfg   = bootcfg_q;
    assign boot_done = boot_done_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pwr_boot_seq.sv
// Self-checking bench for pwr_boot_seq: expected transition edges are derived from the
// sequencing rules with plain arithmetic, with randomised delays and pulse widths.
module tb_pwr_boot_seq;

    localparam int PG_TIMEOUT   = 16;
    localparam int RST_HOLD     = 8;
    localparam int BOOT_TIMEOUT = 64;
    localparam int QUIET        = 10;
    localparam int OFF_CYCLES   = 8;
    localparam int MAX_RETRY    = 2;

    // An input changed just after an edge is acted on by the state register 3 edges later.
    localparam int SYNC_LAT = 3;

    localparam int ST_IDLE = 0, ST_EN_PWR = 1, ST_HOLD = 2, ST_BOOT = 3,
                   ST_DONE = 4, ST_OFF = 5, ST_FAULT = 6;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       pwr_good;
    logic       cs;
    logic       pwr_en;
    logic       dsp_rst_n;
    logic [3:0] bootcfg;
    logic       boot_done;
    logic       fault;
    logic [2:0] state;

    int checks;
    int errors;
    int rst_rises;
    logic prev_rst_n;

    pwr_boot_seq #(
        .BOOTCFG      (4'b1001),
        .CNT_W        (24),
        .PG_TIMEOUT   (PG_TIMEOUT),
        .RST_HOLD     (RST_HOLD),
        .BOOT_TIMEOUT (BOOT_TIMEOUT),
        .QUIET        (QUIET),
        .OFF_CYCLES   (OFF_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .pwr_good  (pwr_good),
        .cs        (cs),
        .pwr_en    (pwr_en),
        .dsp_rst_n (dsp_rst_n),
        .bootcfg   (bootcfg),
        .boot_done (boot_done),
        .fault     (fault),
        .state     (state)
    );

    always #5 clk_in = ~clk_in;

    // Output word a given state must show: {state, pwr_en, dsp_rst_n, bootcfg, boot_done, fault}.
    function automatic logic [10:0] expVec(input int st);
        logic pe, rn, bd, ft;
        logic [3:0] bc;
        logic [2:0] s3;
        s3 = 3'(st);
        pe = (st == ST_EN_PWR) || (st == ST_HOLD) || (st == ST_BOOT) || (st == ST_DONE);
        rn = (st == ST_BOOT) || (st == ST_DONE);
        bc = pe ? 4'b1001 : 4'b0000;
        bd = (st == ST_DONE);
        ft = (st == ST_FAULT);
        return {s3, pe, rn, bc, bd, ft};
    endfunction

    function automatic logic [10:0] obsVec();
        return {state, pwr_en, dsp_rst_n, bootcfg, boot_done, fault};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
        if (dsp_rst_n === 1'b1 && prev_rst_n === 1'b0) rst_rises++;
        prev_rst_n = dsp_rst_n;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic pg, input logic cs_v);
        pwr_good = pg;
        cs       = cs_v;
    endtask

    // State must be reached on exactly the given edge and not earlier.
    task automatic expectAt(input int st, input int edges, input string tag);
        int early;
        early = 0;
        for (int i = 0; i < edges; i++) begin
            tick();
            if (i < edges - 1 && state === 3'(st)) early++;
        end
        checkOutput($sformatf("%s_early", tag), early, 0);
        checkOutput(tag, 32'(obsVec()), 32'(expVec(st)));
    endtask

    task automatic expectHold(input int st, input int n, input string tag);
        int off_state;
        off_state = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (obsVec() !== expVec(st)) off_state++;
        end
        checkOutput(tag, off_state, 0);
    endtask

    task automatic resetDut(input string tag);
        rst_in = 1'b1;
        repeat (3) tick();
        checkOutput($sformatf("%s_rst", tag), 32'(obsVec()), 32'(expVec(ST_IDLE)));
        rst_in = 1'b0;
        expectAt(ST_EN_PWR, 1, $sformatf("%s_en", tag));
    endtask

    initial begin
        int k, s, l, g;
        checks     = 0;
        errors     = 0;
        rst_rises  = 0;
        prev_rst_n = 1'b0;
        rst_in     = 1'b1;
        applyStimulus(1'b0, 1'b1);

        // Normal boot with randomised power-good delay, cs start and cs low width.
        resetDut("s1");
        k = $urandom_range(1, 12);
        expectHold(ST_EN_PWR, k, "s1_wait_pg");
        applyStimulus(1'b1, 1'b1);
        expectAt(ST_HOLD, SYNC_LAT, "s1_hold");
        expectAt(ST_BOOT, RST_HOLD, "s1_boot");
        s = $urandom_range(0, 40);
        expectHold(ST_BOOT, s, "s1_pre_cs");
        applyStimulus(1'b1, 1'b0);
        l = $urandom_range(1, 20);
        expectHold(ST_BOOT, l, "s1_cs_low");
        applyStimulus(1'b1, 1'b1);
        expectAt(ST_DONE, QUIET + 2, "s1_done");
        expectHold(ST_DONE, 5, "s1_done_hold");
        applyStimulus(1'b0, 1'b1);
        expectAt(ST_FAULT, SYNC_LAT, "s1_pg_loss_fault");

        // Power-good never arrives.
        resetDut("s2");
        expectAt(ST_FAULT, PG_TIMEOUT, "s2_fault");
        expectHold(ST_FAULT, 20, "s2_fault_hold");

        // Power-good drops for 4 cycles during HOLD_RST, second attempt succeeds.
        resetDut("s4");
        expectHold(ST_EN_PWR, 2, "s4_wait_pg");
        applyStimulus(1'b1, 1'b1);
        expectAt(ST_HOLD, SYNC_LAT, "s4_hold");
        expectHold(ST_HOLD, 2, "s4_hold_run");
        applyStimulus(1'b0, 1'b1);
        expectAt(ST_OFF, SYNC_LAT, "s4_off");
        expectHold(ST_OFF, 1, "s4_off_run");
        applyStimulus(1'b1, 1'b1);
        expectAt(ST_EN_PWR, OFF_CYCLES - 1, "s4_retry_en");
        expectAt(ST_HOLD, 1, "s4_retry_hold");
        expectAt(ST_BOOT, RST_HOLD, "s4_retry_boot");
        applyStimulus(1'b1, 1'b0);
        expectHold(ST_BOOT, 3, "s4_cs_low");
        applyStimulus(1'b1, 1'b1);
        expectAt(ST_DONE, QUIET + 2, "s4_done");

        // Asynchronous reset on cycle 3 of BOOT.
        resetDut("s5");
        expectAt(ST_HOLD, 2, "s5_hold");
        expectAt(ST_BOOT, RST_HOLD, "s5_boot");
        expectHold(ST_BOOT, 3, "s5_boot_run");
        rst_in = 1'b1;
        #2;
        checkOutput("s5_async_rst", 32'(obsVec()), 32'(expVec(ST_IDLE)));

        // No cs activity: three full attempts, then fault (also shows retry count was cleared).
        resetDut("s3");
        rst_rises = 0;
        expectAt(ST_HOLD, 2, "s3_hold");
        for (int a = 0; a <= MAX_RETRY; a++) begin
            expectAt(ST_BOOT, RST_HOLD, $sformatf("s3_boot%0d", a));
            expectAt(ST_OFF, BOOT_TIMEOUT, $sformatf("s3_timeout%0d", a));
            if (a < MAX_RETRY) begin
                expectAt(ST_EN_PWR, OFF_CYCLES, $sformatf("s3_en%0d", a));
                expectAt(ST_HOLD, 1, $sformatf("s3_hold%0d", a));
            end
        end
        expectAt(ST_FAULT, 1, "s3_fault");
        checkOutput("s3_rst_pulses", rst_rises, MAX_RETRY + 1);

        // Periodic 1-cycle glitches keep restarting the quiet window.
        resetDut("s6");
        expectAt(ST_HOLD, 2, "s6_hold");
        expectAt(ST_BOOT, RST_HOLD, "s6_boot");
        g = $urandom_range(3, 6);
        for (int i = 0; i < g; i++) begin
            applyStimulus(1'b1, 1'b0);
            expectHold(ST_BOOT, 1, $sformatf("s6_glitch%0d", i));
            applyStimulus(1'b1, 1'b1);
            expectHold(ST_BOOT, 7, $sformatf("s6_gap%0d", i));
        end
        expectAt(ST_DONE, QUIET + 2 - 7, "s6_done");

        // cs falling edge lands on the boot-timeout terminal count: timeout cancelled.
        resetDut("s7");
        expectAt(ST_HOLD, 2, "s7_hold");
        expectAt(ST_BOOT, RST_HOLD, "s7_boot");
        expectHold(ST_BOOT, BOOT_TIMEOUT - SYNC_LAT, "s7_pre_cs");
        applyStimulus(1'b1, 1'b0);
        expectHold(ST_BOOT, 4, "s7_edge_at_tc");
        applyStimulus(1'b1, 1'b1);
        expectAt(ST_DONE, QUIET + 2, "s7_done");

        // One cycle later the edge misses the terminal count and the attempt times out.
        resetDut("s8");
        expectAt(ST_HOLD, 2, "s8_hold");
        expectAt(ST_BOOT, RST_HOLD, "s8_boot");
        expectHold(ST_BOOT, BOOT_TIMEOUT - SYNC_LAT + 1, "s8_pre_cs");
        applyStimulus(1'b1, 1'b0);
        expectAt(ST_OFF, SYNC_LAT - 1, "s8_timeout");
        applyStimulus(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
